// File: rtl/rallyx_pkg.sv
// rtl/rallyx_pkg.sv - shared map geometry, headings and probe types
package rallyx_pkg;

   localparam logic [3:0] DIR_YNEG = 4'b0001;
   localparam logic [3:0] DIR_YPOS = 4'b0010;
   localparam logic [3:0] DIR_XPOS = 4'b0100;
   localparam logic [3:0] DIR_XNEG = 4'b1000;

   localparam int TILE_SHIFT  = 4;
   localparam int MAP_W_TILES = 80;
   localparam int MAP_H_TILES = 60;
   localparam int MAP_W_PX    = MAP_W_TILES << TILE_SHIFT;
   localparam int MAP_H_PX    = MAP_H_TILES << TILE_SHIFT;
   localparam int SPRITE_HALF = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_COMMIT
   } probe_state_t;

   // One tag per probe slot, including OOB/suppressed ones, so timing never varies
   typedef struct packed {
      logic       valid;
      logic       rd;
      logic       force_wall;
      logic [2:0] idx;
   } probe_tag_t;

   function automatic logic dir_is_onehot(input logic [3:0] d);
      return (d == DIR_YNEG) || (d == DIR_YPOS) || (d == DIR_XPOS) || (d == DIR_XNEG);
   endfunction

endpackage

// File: rtl/enemy_probe_addr.sv
// rtl/enemy_probe_addr.sv - probe point coordinate, bounds check and tile address
module enemy_probe_addr
   import rallyx_pkg::*;
#(
   parameter int LOOKAHEAD    = SPRITE_HALF + 1,
   parameter int PROBE_SPREAD = 8,
   parameter int TSHIFT       = TILE_SHIFT,
   parameter int W_TILES      = MAP_W_TILES,
   parameter int H_TILES      = MAP_H_TILES
) (
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic [3:0]  dir,
   input  logic [2:0]  idx,
   output logic        oob,
   output logic [12:0] map_addr
);

   localparam logic signed [11:0] X_MAX = 12'((W_TILES << TSHIFT) - 1);
   localparam logic signed [11:0] Y_MAX = 12'((H_TILES << TSHIFT) - 1);
   localparam logic signed [11:0] AHEAD = 12'(LOOKAHEAD);

   logic signed [11:0] cx, cy, lat, px, py;
   logic [11:0] pxu, pyu;

   always_comb begin
      cx  = $signed({1'b0, x});
      cy  = $signed({1'b0, y});
      // (idx-2)*spread; modular 12-bit arithmetic yields the signed offset
      lat = $signed(12'(idx) * 12'(PROBE_SPREAD) - 12'(2 * PROBE_SPREAD));
      px  = cx;
      py  = cy;
      case (dir)
         DIR_YNEG: begin py = cy - AHEAD; px = cx + lat; end
         DIR_YPOS: begin py = cy + AHEAD; px = cx + lat; end
         DIR_XPOS: begin px = cx + AHEAD; py = cy + lat; end
         DIR_XNEG: begin px = cx - AHEAD; py = cy + lat; end
         default:  begin px = cx; py = cy; end
      endcase
      oob = px[11] || py[11] || (px > X_MAX) || (py > Y_MAX);
      pxu = px;
      pyu = py;
      map_addr = 13'd0;
      if (!oob) begin
         map_addr = 13'(13'(pyu >> TSHIFT) * 13'(W_TILES)) + 13'(pxu >> TSHIFT);
      end
   end

endmodule

// File: rtl/enemy_wall_probe.sv
// rtl/enemy_wall_probe.sv - per-frame five-point wall probe ahead of one enemy
module enemy_wall_probe
   import rallyx_pkg::*;
#(
   parameter int LOOKAHEAD    = SPRITE_HALF + 1,
   parameter int PROBE_SPREAD = 8,
   parameter int TSHIFT       = TILE_SHIFT,
   parameter int W_TILES      = MAP_W_TILES,
   parameter int H_TILES      = MAP_H_TILES,
   parameter int ROM_LAT      = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic [10:0] EnemyX,
   input  logic [10:0] EnemyY,
   input  logic [3:0]  enemyVelocity,
   output logic        map_rd,
   output logic [12:0] map_addr,
   input  logic        map_data,
   output logic [4:0]  mapE_on,
   output logic        mapE_valid,
   output logic        busy,
   output logic        overrun
);

   probe_state_t state_q, state_d;
   logic [10:0]  x_q, y_q;
   logic [3:0]   dir_q;
   logic [2:0]   idx_q;
   logic [4:0]   result_q, result_d;
   logic [4:0]   mapE_on_q;
   logic         overrun_q;
   probe_tag_t   tag_q [ROM_LAT];
   probe_tag_t   new_tag, emerge;

   logic dir_ok, probe_oob, issuing, pending, start, commit_load;
   logic [12:0] probe_addr;

   enemy_probe_addr #(
      .LOOKAHEAD    (LOOKAHEAD),
      .PROBE_SPREAD (PROBE_SPREAD),
      .TSHIFT       (TSHIFT),
      .W_TILES      (W_TILES),
      .H_TILES      (H_TILES)
   ) u_addr (
      .x        (x_q),
      .y        (y_q),
      .dir      (dir_q),
      .idx      (idx_q),
      .oob      (probe_oob),
      .map_addr (probe_addr)
   );

   always_comb begin
      dir_ok   = dir_is_onehot(dir_q);
      issuing  = (state_q == ST_ISSUE);
      map_rd   = issuing && dir_ok && !probe_oob;
      map_addr = map_rd ? probe_addr : 13'd0;

      new_tag            = '0;
      new_tag.valid      = issuing;
      new_tag.rd         = map_rd;
      new_tag.force_wall = issuing && dir_ok && probe_oob;
      new_tag.idx        = issuing ? idx_q : 3'd0;

      emerge   = tag_q[ROM_LAT-1];
      result_d = result_q;
      if (emerge.valid) begin
         result_d[emerge.idx] = emerge.rd ? map_data : emerge.force_wall;
      end

      // Final data emerges this cycle once no earlier stage still holds a tag
      pending = 1'b0;
      for (int i = 0; i < ROM_LAT - 1; i++) begin
         pending = pending | tag_q[i].valid;
      end

      start       = frame_start && ((state_q == ST_IDLE) || (state_q == ST_COMMIT));
      commit_load = (state_q == ST_DRAIN) && !pending;

      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_ISSUE;
         ST_ISSUE:  if (idx_q == 3'd4) state_d = (ROM_LAT == 1) ? ST_COMMIT : ST_DRAIN;
         ST_DRAIN:  if (!pending) state_d = ST_COMMIT;
         ST_COMMIT: state_d = start ? ST_ISSUE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // With ROM_LAT=1 the last tag emerges in the first post-issue cycle
      if ((state_q == ST_ISSUE) && (idx_q == 3'd4) && (ROM_LAT == 1)) state_d = ST_DRAIN;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         dir_q     <= '0;
         idx_q     <= '0;
         result_q  <= '0;
         mapE_on_q <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            x_q      <= EnemyX;
            y_q      <= EnemyY;
            dir_q    <= enemyVelocity;
            idx_q    <= 3'd0;
            result_q <= 5'd0;
         end else begin
            if (issuing) idx_q <= idx_q + 3'd1;
            result_q <= result_d;
         end
         if (commit_load) mapE_on_q <= result_d;
         if (frame_start && busy) overrun_q <= 1'b1;
         tag_q[0] <= new_tag;
         for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign mapE_on    = mapE_on_q;
   assign mapE_valid = (state_q == ST_COMMIT);
   assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_enemy_wall_probe.sv
// tb/tb_enemy_wall_probe.sv - directed self-checking bench for enemy_wall_probe
module tb_enemy_wall_probe;
   import rallyx_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_start;
   logic [10:0] EnemyX, EnemyY;
   logic [3:0]  enemyVelocity;
   logic        map_rd;
   logic [12:0] map_addr;
   logic        map_data;
   logic [4:0]  mapE_on;
   logic        mapE_valid, busy, overrun;

   int checks = 0;
   int errors = 0;
   int rom_mode = 0;
   logic rom_s1 = 1'b0;
   logic [4:0] prev_on = 5'd0;
   logic ov_exp = 1'b0;

   enemy_wall_probe dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_start   (frame_start),
      .EnemyX        (EnemyX),
      .EnemyY        (EnemyY),
      .enemyVelocity (enemyVelocity),
      .map_rd        (map_rd),
      .map_addr      (map_addr),
      .map_data      (map_data),
      .mapE_on       (mapE_on),
      .mapE_valid    (mapE_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 Clk = ~Clk;

   function automatic logic wall(input logic [12:0] a);
      case (rom_mode)
         0:       return 1'b0;
         1:       return (a == 13'd2260);
         default: return 1'b1;
      endcase
   endfunction

   // Two-cycle latency map ROM
   initial map_data = 1'b0;
   always @(posedge Clk) begin
      rom_s1   <= map_rd ? wall(map_addr) : 1'b0;
      map_data <= rom_s1;
   end

   task automatic next_cycle();
      @(negedge Clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Called at the negedge of the cycle in which frame_start is presented
   task automatic run(input string name, input logic [10:0] x, input logic [10:0] y,
                      input logic [3:0] dir, input logic [4:0][12:0] addrs,
                      input logic [4:0] rd_mask, input logic [4:0] exp_on, input logic ov);
      frame_start   = 1'b1;
      EnemyX        = x;
      EnemyY        = y;
      enemyVelocity = dir;
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         frame_start = 1'b0;
         if (ov && c == 3) begin
            frame_start   = 1'b1;
            EnemyX        = 11'd1270;
            enemyVelocity = DIR_XPOS;
         end
         if (ov && c == 4) ov_exp = 1'b1;
         if (c <= 5) begin
            check($sformatf("%s c%0d map_rd", name, c), 32'(map_rd), 32'(rd_mask[c-1]));
            check($sformatf("%s c%0d map_addr", name, c), 32'(map_addr),
                  rd_mask[c-1] ? 32'(addrs[c-1]) : 32'd0);
         end else begin
            check($sformatf("%s c%0d map_rd", name, c), 32'(map_rd), 32'd0);
            check($sformatf("%s c%0d map_addr", name, c), 32'(map_addr), 32'd0);
         end
         check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= 7));
         check($sformatf("%s c%0d valid", name, c), 32'(mapE_valid), 32'(c == 8));
         check($sformatf("%s c%0d overrun", name, c), 32'(overrun), 32'(ov_exp));
         check($sformatf("%s c%0d mapE_on", name, c), 32'(mapE_on),
               (c == 8) ? 32'(exp_on) : 32'(prev_on));
      end
      prev_on = exp_on;
   endtask

   initial begin
      Reset         = 1'b1;
      frame_start   = 1'b0;
      EnemyX        = '0;
      EnemyY        = '0;
      enemyVelocity = '0;
      next_cycle();
      next_cycle();
      check("reset map_rd", 32'(map_rd), 32'd0);
      check("reset map_addr", 32'(map_addr), 32'd0);
      check("reset mapE_on", 32'(mapE_on), 32'd0);
      check("reset valid", 32'(mapE_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      Reset = 1'b0;
      next_cycle();

      rom_mode = 1;
      run("ypos_wall", 11'd320, 11'd440, DIR_YPOS,
          {13'd2261, 13'd2260, 13'd2260, 13'd2259, 13'd2259}, 5'b11111, 5'b01100, 1'b0);
      next_cycle();
      run("xpos_oob", 11'd1270, 11'd100, DIR_XPOS, '0, 5'b00000, 5'b11111, 1'b0);
      next_cycle();
      rom_mode = 0;
      run("left_edge", 11'd10, 11'd500, DIR_YPOS,
          {13'd2561, 13'd2561, 13'd2560, 13'd2560, 13'd0}, 5'b11110, 5'b00001, 1'b0);
      next_cycle();
      run("bad_dir", 11'd640, 11'd480, 4'b0000, '0, 5'b00000, 5'b00000, 1'b0);
      next_cycle();
      run("bad_dir2", 11'd640, 11'd480, 4'b0101, '0, 5'b00000, 5'b00000, 1'b0);
      next_cycle();

      rom_mode = 1;
      run("overrun", 11'd320, 11'd440, DIR_YPOS,
          {13'd2261, 13'd2260, 13'd2260, 13'd2259, 13'd2259}, 5'b11111, 5'b01100, 1'b1);
      run("chained", 11'd10, 11'd500, DIR_YPOS,
          {13'd2561, 13'd2561, 13'd2560, 13'd2560, 13'd0}, 5'b11110, 5'b00001, 1'b0);
      next_cycle();

      // Mid-operation reset while the ROM returns all ones
      rom_mode      = 2;
      frame_start   = 1'b1;
      EnemyX        = 11'd320;
      EnemyY        = 11'd440;
      enemyVelocity = DIR_YPOS;
      next_cycle();
      frame_start = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      Reset = 1'b1;
      next_cycle();
      Reset = 1'b0;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset map_rd", 32'(map_rd), 32'd0);
      check("midreset mapE_on", 32'(mapE_on), 32'd0);
      check("midreset overrun", 32'(overrun), 32'd0);
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         check($sformatf("postreset k%0d valid", k), 32'(mapE_valid), 32'd0);
         check($sformatf("postreset k%0d mapE_on", k), 32'(mapE_on), 32'd0);
         check($sformatf("postreset k%0d busy", k), 32'(busy), 32'd0);
      end
      prev_on  = 5'd0;
      ov_exp   = 1'b0;
      rom_mode = 1;
      run("after_reset", 11'd320, 11'd440, DIR_YPOS,
          {13'd2261, 13'd2260, 13'd2260, 13'd2259, 13'd2259}, 5'b11111, 5'b01100, 1'b0);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
